// File: rtl/sw_db_pkg.sv
// Shared types and helpers for the slide-switch debouncer.
// Holds the per-channel FSM state encoding and the counter width calculation.
package sw_db_pkg;

    typedef enum logic [1:0] {
        ST_LO = 2'b00,
        WT_HI = 2'b01,
        ST_HI = 2'b10,
        WT_LO = 2'b11
    } db_state_t;

    // Narrowest counter that can hold 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: 2-flop synchroniser, counter-based debounce FSM and
// one-cycle rise/fall pulses registered alongside the accepted level.
module debounce_ch
    import sw_db_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (sync2_q) begin
                    state_d = WT_HI;
                    cnt_d   = '0;
                end
            end
            WT_HI: begin
                if (!sync2_q) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (!sync2_q) begin
                    state_d = WT_LO;
                    cnt_d   = '0;
                end
            end
            WT_LO: begin
                if (sync2_q) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // The accepted level is high in ST_HI and while a fall is still pending.
    assign db_o   = (state_q == ST_HI) || (state_q == WT_LO);
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_CH slide switches ahead of the button PIO.
// Define SW_EDGE_LATCH_EN to add sticky rise flags (sw_edge) cleared by edge_clr.
module sw_debounce
    import sw_db_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_raw,
    output logic [N_CH-1:0] sw_db,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall
`ifdef SW_EDGE_LATCH_EN
    ,
    input  logic [N_CH-1:0] edge_clr,
    output logic [N_CH-1:0] sw_edge
`endif
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk_i (CLOCK_50),
                .rst_i (reset),
                .sw_i  (sw_raw[gi]),
                .db_o  (sw_db[gi]),
                .rise_o(sw_rise[gi]),
                .fall_o(sw_fall[gi])
            );
        end
    endgenerate

`ifdef SW_EDGE_LATCH_EN
    logic [N_CH-1:0] edge_q, edge_d;

    // Set has priority over clear so a rise coinciding with a clear is kept.
    assign edge_d = (edge_q & ~edge_clr) | sw_rise;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign sw_edge = edge_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with DEBOUNCE_CYCLES=4: directed scenarios
// followed by random switch activity, compared every cycle against a run-length model.
module tb_sw_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_db;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
`ifdef SW_EDGE_LATCH_EN
    logic [N-1:0] edge_clr;
    logic [N-1:0] sw_edge;
`endif

    always #5 clk = ~clk;

    sw_debounce #(
        .N_CH           (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
`ifdef SW_EDGE_LATCH_EN
        ,
        .edge_clr(edge_clr),
        .sw_edge (sw_edge)
`endif
    );

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // Model: the FSM sees the raw level two edges late; the output flips once
    // D+1 consecutive delayed samples disagree with the accepted level.
    bit [N-1:0] m_d1, m_d2, m_db, m_rise, m_fall, m_edge;
    int         m_run [N];

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_edge = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_no);
        end
    endtask

    task automatic check_all();
        chk("sw_db", 32'(sw_db), 32'(m_db));
        chk("sw_rise", 32'(sw_rise), 32'(m_rise));
        chk("sw_fall", 32'(sw_fall), 32'(m_fall));
`ifdef SW_EDGE_LATCH_EN
        chk("sw_edge", 32'(sw_edge), 32'(m_edge));
`endif
    endtask

    task automatic tick();
        bit [N-1:0] smp;
        @(posedge clk);
        tick_no++;
        if (rst) begin
            model_reset();
        end else begin
`ifdef SW_EDGE_LATCH_EN
            m_edge = (m_edge & ~edge_clr) | m_rise;
`endif
            smp  = m_d2;
            m_d2 = m_d1;
            m_d1 = sw_raw;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (smp[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        m_db[c]  = smp[c];
                        m_run[c] = 0;
                        if (smp[c]) m_rise[c] = 1'b1;
                        else        m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  pulses;
        int  rises;
        int  rise_tick;
        int  sample_tick;
        bit  seen_hi;
        bit  pat [10];
        int  hold [N];

        sw_raw = '0;
`ifdef SW_EDGE_LATCH_EN
        edge_clr = '0;
`endif
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        chk("reset_db", 32'(sw_db), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 1: clean rise on ch0, latency 7 edges
        sw_raw[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (sw_db[0]) break;
        end
        chk("t1_latency", 32'(n), 32'd7);
        chk("t1_rise_pulse", 32'(sw_rise[0]), 32'd1);
        tick();
        chk("t1_rise_one_cycle", 32'(sw_rise[0]), 32'd0);
        repeat (3) tick();

        // 2: short pulse rejected, long pulse accepted on ch1
        pulses = 0;
        sw_raw[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); pulses += int'(sw_rise[1] | sw_fall[1]); end
        sw_raw[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); pulses += int'(sw_rise[1] | sw_fall[1]); end
        chk("t2_short_pulses", 32'(pulses), 32'd0);
        chk("t2_short_db", 32'(sw_db[1]), 32'd0);
        seen_hi = 1'b0;
        sw_raw[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); seen_hi |= sw_db[1]; end
        sw_raw[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); seen_hi |= sw_db[1]; end
        chk("t2_long_accepted", 32'(seen_hi), 32'd1);

        // 3: bounce on ch2, single rise timed from the last 0->1 sample
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rises = 0;
        rise_tick = -1;
        sample_tick = -1;
        for (int i = 0; i < 20; i++) begin
            sw_raw[2] = (i < 10) ? pat[i] : 1'b1;
            tick();
            if (i == 5) sample_tick = tick_no;
            if (sw_rise[2]) begin rises++; rise_tick = tick_no; end
        end
        chk("t3_rise_count", 32'(rises), 32'd1);
        chk("t3_rise_latency", 32'(rise_tick - sample_tick + 1), 32'd7);

        // 4: fall on ch0 with no rise
        sw_raw[0] = 1'b0;
        n = 0;
        rises = 0;
        while (n < 20) begin
            tick();
            n++;
            rises += int'(sw_rise[0]);
            if (!sw_db[0]) break;
        end
        chk("t4_latency", 32'(n), 32'd7);
        chk("t4_fall_pulse", 32'(sw_fall[0]), 32'd1);
        chk("t4_no_rise", 32'(rises), 32'd0);

        // 5: reset during WT_HI on ch3 (cnt=2), then debounce from release
        sw_raw[3] = 1'b1;
        repeat (5) tick();
        apply_reset();
        chk("t5_reset_db", 32'(sw_db), 32'd0);
        chk("t5_reset_rise", 32'(sw_rise), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (sw_rise[3]) break;
        end
        chk("t5_rise_after_release", 32'(n), 32'd7);

`ifdef SW_EDGE_LATCH_EN
        // 6: sticky flag, clear, and set-beats-clear
        sw_raw[1] = 1'b1;
        n = 0;
        while (n < 20) begin tick(); n++; if (sw_rise[1]) break; end
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin tick(); n += int'(sw_edge[1]); end
        chk("t6_sticky_hold", 32'(n), 32'd20);
        edge_clr[1] = 1'b1;
        tick();
        edge_clr[1] = 1'b0;
        chk("t6_cleared", 32'(sw_edge[1]), 32'd0);
        sw_raw[1] = 1'b0;
        repeat (12) tick();
        sw_raw[1] = 1'b1;
        n = 0;
        while (n < 20) begin tick(); n++; if (sw_rise[1]) break; end
        edge_clr[1] = 1'b1;
        tick();
        edge_clr[1] = 1'b0;
        chk("t6_set_wins", 32'(sw_edge[1]), 32'd1);
`endif

        // Random activity on all channels, occasional clears
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int t = 0; t < 500; t++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sw_raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                           : int'($urandom_range(0, 4));
                end else begin
                    hold[c]--;
                end
            end
`ifdef SW_EDGE_LATCH_EN
            edge_clr = N'($urandom_range(0, 15)) & {N{($urandom_range(0, 7) == 0)}};
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
